led_pattern_checker: RTL and testbench
======================================

Name: led_pattern_checker

Overview:
Receive-side monitor for the 8-bit LED pattern bus driven by the free-running pattern sequencer. Samples the bus on the fast system clock, decodes each pattern back to its step index 0..6, and checks that every change is the legal successor step. Reports lock, step index, sequence errors, completed laps and a stalled-sequencer condition. Sits on the same board clock as the sequencer, feeding status LEDs or a debug readout.

Parameters:
STALL_CYCLES, 24'd12000000, clk cycles without a bus change before stalled asserts (≈ two slow-clock periods)
ERR_W, 8, width of saturating error counter
LAP_W, 16, width of wrapping lap counter

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous reset, active-high
pat_in  input  8  LED pattern bus from sequencer
state_idx  output  3  last accepted step index (0..6)
idx_valid  output  1  one-cycle pulse when state_idx updates
locked  output  1  checker is tracking a legal sequence
seq_err  output  1  one-cycle pulse on illegal change while locked
err_count  output  ERR_W  saturating count of seq_err pulses
lap_count  output  LAP_W  wrapping count of completed S6->S0 transitions
stalled  output  1  no bus change for STALL_CYCLES while locked

Behaviour:
- Pattern table, step index -> code: 0=8'h00, 1=8'h18, 2=8'h3C, 3=8'h7E, 4=8'hE7, 5=8'hC3, 6=8'h81. Any other code decodes to 3'd7 (invalid).
- Sampling: pat_q <= pat_in; pat_prev <= pat_q every clk. change = (pat_q != pat_prev); decode operates on pat_q.
- Latency: pat_in changes before edge k -> pat_q at edge k -> all outputs updated at edge k+1.
- Reset (rst=1 at an edge): pat_q=pat_prev=0, FSM=HUNT, state_idx=0, idx_valid=0, locked=0, seq_err=0, err_count=0, lap_count=0, stalled=0, stall counter=0. Applies mid-operation identically.
- FSM HUNT: locked=0. On change with decoded idx==0 -> LOCKED, state_idx=0, idx_valid pulse. All other changes, including invalid codes, ignored (no seq_err).
- FSM LOCKED: locked=1. On change:
  - decoded == (state_idx==6 ? 0 : state_idx+1) -> state_idx=decoded, idx_valid pulse; if state_idx was 6, lap_count +1 (wraps at 2^LAP_W).
  - otherwise (wrong step, backward step, invalid code) -> seq_err pulse, err_count +1 saturating at all-ones, state_idx holds, FSM -> HUNT.
- No change -> FSM and state_idx hold; idx_valid, seq_err low.
- Stall counter: cleared on any change, and in HUNT; increments each cycle while LOCKED with no change, saturating at STALL_CYCLES. stalled=1 when counter == STALL_CYCLES; cleared on the edge that registers the next change, or on leaving LOCKED.
- Simultaneous: change that causes seq_err also clears stall counter and stalled. idx_valid and seq_err never both high.
- Sequencer holding a step (in=1) is legal; only stalled reports it.

Decomposition:
- Package led_pattern_pkg: PAT_S0..PAT_S6 localparams, IDX_W=3, IDX_INVALID=3'd7, FSM state encoding (HUNT, LOCKED).
- Sub-module led_pattern_decode: combinational 8-bit code -> 3-bit index, shared with the sequencer's bench.

Test Plan:
- Reset, drive 8'hFF 4 cycles then 00,18,3C,7E,E7,C3,81,00 each held 4 cycles -> locked=1 from 2nd edge after 00, state_idx steps 0..6,0, eight idx_valid pulses, lap_count=1, err_count=0.
- Locked at 3C (idx 2), drive E7 -> seq_err single pulse, err_count=1, locked=0; following 7E ignored; then 00 -> relock, state_idx=0.
- Locked at 18, drive 8'h55 -> seq_err, err_count+1, HUNT; backward step 7E->3C from a fresh lock gives same result.
- STALL_CYCLES=16: lock, hold 7E -> stalled=1 exactly 16 cycles after last change registered; drive E7 -> stalled=0 and idx_valid on same edge.
- ERR_W=2: five illegal changes (relocking between) -> err_count 1,2,3,3,3.
- Locked at E7 with lap_count=2, assert rst one cycle -> next edge all outputs 0, HUNT; holding E7 afterwards produces no lock.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern checker: step codes, index encoding
// and the checker FSM states.
package led_pattern_pkg;

  localparam int IDX_W = 3;

  localparam logic [7:0] PAT_S0 = 8'h00;
  localparam logic [7:0] PAT_S1 = 8'h18;
  localparam logic [7:0] PAT_S2 = 8'h3C;
  localparam logic [7:0] PAT_S3 = 8'h7E;
  localparam logic [7:0] PAT_S4 = 8'hE7;
  localparam logic [7:0] PAT_S5 = 8'hC3;
  localparam logic [7:0] PAT_S6 = 8'h81;

  localparam logic [IDX_W-1:0] IDX_FIRST   = 3'd0;
  localparam logic [IDX_W-1:0] IDX_LAST    = 3'd6;
  localparam logic [IDX_W-1:0] IDX_INVALID = 3'd7;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  // Legal successor of a step; the sequence wraps from the last step to the first.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_LAST) ? IDX_FIRST : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/led_pattern_decode.sv
// Combinational LED pattern decoder: 8-bit bus code to step index, with
// IDX_INVALID for any code outside the step table.
module led_pattern_decode
  import led_pattern_pkg::*;
(
  input  logic [7:0]       code,
  output logic [IDX_W-1:0] idx
);

  // NOTE: a default on every path keeps this purely combinational (no latch).
  always_comb begin
    idx = IDX_INVALID;
    unique case (code)
      PAT_S0:  idx = 3'd0;
      PAT_S1:  idx = 3'd1;
      PAT_S2:  idx = 3'd2;
      PAT_S3:  idx = 3'd3;
      PAT_S4:  idx = 3'd4;
      PAT_S5:  idx = 3'd5;
      PAT_S6:  idx = 3'd6;
      default: idx = IDX_INVALID;
    endcase
  end

endmodule

// File: rtl/led_pattern_checker.sv
// Receive-side monitor for the LED pattern bus: tracks the step sequence,
// flags illegal steps, counts laps and reports a stalled sequencer.
module led_pattern_checker
  import led_pattern_pkg::*;
#(
  parameter logic [23:0] STALL_CYCLES = 24'd12000000,
  parameter int          ERR_W        = 8,
  parameter int          LAP_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       pat_in,
  output logic [IDX_W-1:0] state_idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count,
  output logic [LAP_W-1:0] lap_count,
  output logic             stalled
);

  logic [7:0]       pat_q;
  logic [7:0]       pat_prev;
  logic             change;
  logic [IDX_W-1:0] dec_idx;
  logic [23:0]      stall_cnt;
  chk_state_e       state;

  led_pattern_decode u_decode (
    .code (pat_q),
    .idx  (dec_idx)
  );

  assign change = (pat_q != pat_prev);
  assign locked = (state == LOCKED);

  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge values; the reset is synchronous and covers every flop here.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= '0;
      pat_prev  <= '0;
      state     <= HUNT;
      state_idx <= IDX_FIRST;
      idx_valid <= 1'b0;
      seq_err   <= 1'b0;
      err_count <= '0;
      lap_count <= '0;
      stalled   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      pat_q     <= pat_in;
      pat_prev  <= pat_q;
      idx_valid <= 1'b0;
      seq_err   <= 1'b0;

      unique case (state)
        HUNT: begin
          stall_cnt <= '0;
          stalled   <= 1'b0;
          // Only a fresh arrival at step 0 starts tracking; everything else is noise.
          if (change && dec_idx == IDX_FIRST) begin
            state     <= LOCKED;
            state_idx <= IDX_FIRST;
            idx_valid <= 1'b1;
          end
        end

        LOCKED: begin
          if (change) begin
            stall_cnt <= '0;
            stalled   <= 1'b0;
            if (dec_idx == next_idx(state_idx)) begin
              state_idx <= dec_idx;
              idx_valid <= 1'b1;
              if (state_idx == IDX_LAST) begin
                lap_count <= lap_count + LAP_W'(1);
              end
            end else begin
              seq_err <= 1'b1;
              state   <= HUNT;
              if (err_count != {ERR_W{1'b1}}) begin
                err_count <= err_count + ERR_W'(1);
              end
            end
          end else if (stall_cnt != STALL_CYCLES) begin
            // Counter parks at the threshold so stalled stays asserted.
            stall_cnt <= stall_cnt + 24'd1;
            stalled   <= ((stall_cnt + 24'd1) == STALL_CYCLES);
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_checker.sv
// Randomized self-checking bench for led_pattern_checker against a
// cycle-level behavioural model of the step-sequence rules.
module tb_led_pattern_checker;

  localparam logic [23:0] STALL = 24'd16;
  localparam int ERR_W = 2;
  localparam int LAP_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       pat_in = 8'h00;
  logic [2:0]       state_idx;
  logic             idx_valid;
  logic             locked;
  logic             seq_err;
  logic [ERR_W-1:0] err_count;
  logic [LAP_W-1:0] lap_count;
  logic             stalled;

  led_pattern_checker #(
    .STALL_CYCLES (STALL),
    .ERR_W        (ERR_W),
    .LAP_W        (LAP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pat_in    (pat_in),
    .state_idx (state_idx),
    .idx_valid (idx_valid),
    .locked    (locked),
    .seq_err   (seq_err),
    .err_count (err_count),
    .lap_count (lap_count),
    .stalled   (stalled)
  );

  always #5 clk = ~clk;

  logic [7:0] codes [0:6] = '{8'h00, 8'h18, 8'h3C, 8'h7E, 8'hE7, 8'hC3, 8'h81};

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state: the two most recent bus samples and the tracker.
  int m_q, m_prev, m_locked, m_idx, m_errs, m_laps, m_quiet, e_iv, e_se;

  function automatic int dec(input int code);
    for (int i = 0; i < 7; i++) begin
      if (int'(codes[i]) == code) return i;
    end
    return 7;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input int v, input bit r);
    int d;
    e_iv = 0;
    e_se = 0;
    if (r) begin
      m_q = 0; m_prev = 0; m_locked = 0; m_idx = 0;
      m_errs = 0; m_laps = 0; m_quiet = 0;
      return;
    end
    d = dec(m_q);
    if (m_q != m_prev) begin
      m_quiet = 0;
      if (m_locked == 0) begin
        if (d == 0) begin
          m_locked = 1; m_idx = 0; e_iv = 1;
        end
      end else if (d == (m_idx + 1) % 7) begin
        if (m_idx == 6) m_laps = (m_laps + 1) % (2 ** LAP_W);
        m_idx = d;
        e_iv = 1;
      end else begin
        e_se = 1;
        m_locked = 0;
        if (m_errs < 2 ** ERR_W - 1) m_errs++;
      end
    end else if (m_locked != 0) begin
      m_quiet++;
    end else begin
      m_quiet = 0;
    end
    m_prev = m_q;
    m_q = v;
  endtask

  task automatic step(input logic [7:0] v, input logic r);
    @(negedge clk);
    pat_in = v;
    rst = r;
    @(posedge clk);
    model_edge(int'(v), r);
    #1;
    cyc++;
    check("state_idx", 32'(state_idx), 32'(m_idx));
    check("idx_valid", 32'(idx_valid), 32'(e_iv));
    check("locked",    32'(locked),    32'(m_locked));
    check("seq_err",   32'(seq_err),   32'(e_se));
    check("err_count", 32'(err_count), 32'(m_errs));
    check("lap_count", 32'(lap_count), 32'(m_laps));
    check("stalled",   32'(stalled),   32'((m_locked != 0) && (m_quiet >= int'(STALL))));
  endtask

  initial begin
    int gen_step;
    int r;
    int hold;
    logic [7:0] v;
    logic [7:0] last_v;

    repeat (3) step(8'h00, 1'b1);

    // Directed opening: noise, then one full lap of the sequence.
    repeat (4) step(8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (4) step(codes[i % 7], 1'b0);
    end
    check("lap_after_first_lap", 32'(lap_count), 32'd1);
    check("err_after_first_lap", 32'(err_count), 32'd0);

    // Randomized segments: mostly legal steps, with relocks, jumps, junk,
    // long holds around the stall threshold and occasional resets.
    gen_step = 0;
    last_v = 8'h00;
    for (int seg = 0; seg < 600; seg++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        step(last_v, 1'b1);
        continue;
      end else if (r < 70) begin
        gen_step = (gen_step + 1) % 7;
        v = codes[gen_step];
      end else if (r < 78) begin
        gen_step = 0;
        v = codes[0];
      end else if (r < 88) begin
        gen_step = int'($urandom_range(0, 6));
        v = codes[gen_step];
      end else begin
        v = 8'($urandom_range(0, 255));
      end
      hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 20))
                                         : int'($urandom_range(1, 4));
      repeat (hold) step(v, 1'b0);
      last_v = v;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
